// File: rtl/sim_run_ctrl.sv
// Bench run controller: counts cycles/retires, ends the run on halt+drain, cycle limit or retire hang.
// All outputs registered, one-cycle update; pause freezes everything, DONE absorbs until reset.
module sim_run_ctrl #(
  parameter int CYCLE_W      = 32,
  parameter int MAX_CYCLES   = 1000,
  parameter int WD_LIMIT     = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int FINISH_EN    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               retire,
  input  logic               pause,
  output logic [CYCLE_W-1:0] cycles,
  output logic [CYCLE_W-1:0] retired,
  output logic               running,
  output logic               done,
  output logic [1:0]         reason
);

  localparam int IDLE_W  = (WD_LIMIT > 0) ? $clog2(WD_LIMIT + 1) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CYCLE_W-1:0] MAX_C      = CYCLE_W'(MAX_CYCLES);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(WD_LIMIT);
  localparam logic [IDLE_W-1:0]  WD_LAST    = IDLE_W'((WD_LIMIT > 0) ? WD_LIMIT - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [1:0] R_NONE  = 2'd0;
  localparam logic [1:0] R_HALT  = 2'd1;
  localparam logic [1:0] R_LIMIT = 2'd2;
  localparam logic [1:0] R_HANG  = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [IDLE_W-1:0]  idle;
  logic [DRAIN_W-1:0] drain;

  logic               at_limit;
  logic               hang_hit;
  logic               end_now;
  logic [1:0]         end_reason;
  logic [CYCLE_W-1:0] cycles_nxt;
  logic [CYCLE_W-1:0] retired_nxt;
  logic [IDLE_W-1:0]  idle_nxt;

  assign at_limit    = (cycles == MAX_C);
  assign hang_hit    = (WD_LIMIT != 0) && (idle == WD_LAST) && !retire;
  assign cycles_nxt  = at_limit ? cycles : cycles + CYCLE_W'(1);
  assign retired_nxt = retired + CYCLE_W'(retire);
  // idle saturates rather than wrapping; with the watchdog disabled it stays at 0
  assign idle_nxt    = retire ? '0 : ((idle == IDLE_MAX) ? idle : idle + IDLE_W'(1));

  // End-of-run arbitration: LIMIT beats HALT beats HANG
  always_comb begin
    end_now    = 1'b0;
    end_reason = R_NONE;
    if (at_limit) begin
      end_now    = 1'b1;
      end_reason = R_LIMIT;
    end else if (state == S_RUN && halt) begin
      if (DRAIN_CYCLES == 0) begin
        end_now    = 1'b1;
        end_reason = R_HALT;
      end
    end else if (state == S_RUN && hang_hit) begin
      end_now    = 1'b1;
      end_reason = R_HANG;
    end else if (state == S_DRAIN && drain == '0) begin
      end_now    = 1'b1;
      end_reason = R_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      cycles  <= '0;
      retired <= '0;
      idle    <= '0;
      drain   <= '0;
      reason  <= R_NONE;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (!pause && state != S_DONE) begin
      cycles  <= cycles_nxt;
      retired <= retired_nxt;
      if (state == S_RUN) begin
        idle <= idle_nxt;
      end
      if (end_now) begin
        state   <= S_DONE;
        reason  <= end_reason;
        running <= 1'b0;
        done    <= 1'b1;
`ifndef SYNTHESIS
        $display("run end reason=%0d cycles=%0d retired=%0d", end_reason, cycles_nxt, retired_nxt);
        if (FINISH_EN != 0) begin
          $finish;
        end
`endif
      end else if (state == S_RUN && halt) begin
        state <= S_DRAIN;
        drain <= DRAIN_INIT;
      end else if (state == S_DRAIN) begin
        drain <= drain - DRAIN_W'(1);
      end
    end
  end

endmodule
